// File: rtl/jtframe_lfbuf_sdctrl.sv
// SDRAM-side controller for the line-based frame buffer.
//
// Dumps each completed object line from the input line buffer to SDRAM,
// clearing every word behind itself, then pulses fb_done. On every
// horizontal-blank falling edge (outside vertical blank) it fetches the next
// displayed line from the opposite frame into the output line buffer. Reads
// pre-empt an in-progress dump at word boundaries; the dump resumes afterwards.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   ln_hs, ln_v       line start strobe and line number being drawn
//   frame             frame being written (displayed frame is ~frame)
//   vrender           line to fetch for display
//   lvbl, lhbl        vertical / horizontal blank, active low
//   line              input line-buffer half being dumped
//   fb_addr/fb_din    dump-half read port (1-cycle latency), fb_clr clears a word
//   fb_done           one-cycle pulse when a dump finishes
//   rd_addr/fb_dout   output line-buffer write port, strobed by scr_we
//   ext_*             single-outstanding 32-bit SDRAM port
module jtframe_lfbuf_sdctrl #(
    parameter int VW     = 8,
    parameter int HW     = 9,
    parameter int HWORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ln_hs,
    input  logic [VW-1:0]     ln_v,
    input  logic              frame,
    input  logic [VW-1:0]     vrender,
    input  logic              lvbl,
    input  logic              lhbl,
    output logic              line,
    output logic [HW-2:0]     fb_addr,
    input  logic [31:0]       fb_din,
    output logic              fb_clr,
    output logic              fb_done,
    output logic [HW-2:0]     rd_addr,
    output logic [31:0]       fb_dout,
    output logic              scr_we,
    output logic [VW+HW-1:0]  ext_addr,
    output logic              ext_wr,
    output logic              ext_rd,
    output logic [31:0]       ext_din,
    input  logic [31:0]       ext_dout,
    input  logic              ext_ack
);

    localparam logic [HW-2:0] LAST = (HW-1)'(HWORDS-1);
    localparam logic [HW-2:0] ONE  = (HW-1)'(1);

    typedef enum logic [2:0] {IDLE, W_SET, W_REQ, W_CLR, R_REQ} state_t;
    state_t state, nx_state;

    logic          have_lat, lat_frame, dump_valid, dump_frame;
    logic [VW-1:0] lat_v, dump_v, rd_v;
    logic          wr_pend, rd_pend, lhbl_l;
    logic [HW-2:0] wcnt, rcnt;
    logic          wr_clr, r_ack;

    // A new line start is only taken once the previous dump is fully done
    wire hs_ok   = ln_hs & ~wr_pend;
    wire rd_edge = lhbl_l & ~lhbl & lvbl;

    assign ext_din = fb_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nx_state;
    end

    always_comb begin
        nx_state = state;
        fb_done  = 1'b0;
        fb_clr   = 1'b0;
        ext_wr   = 1'b0;
        ext_rd   = 1'b0;
        fb_addr  = '0;
        ext_addr = '0;
        wr_clr   = 1'b0;
        r_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_pend) nx_state = R_REQ;
                else if (wr_pend) begin
                    // The first line after reset has nothing behind it to dump
                    if (!dump_valid) begin
                        fb_done = 1'b1;
                        wr_clr  = 1'b1;
                    end else nx_state = W_SET;
                end
            end
            W_SET: begin
                fb_addr  = wcnt;      // let the BRAM output settle
                nx_state = W_REQ;
            end
            W_REQ: begin
                fb_addr  = wcnt;
                ext_wr   = 1'b1;
                ext_addr = {dump_frame, dump_v, wcnt};
                if (ext_ack) nx_state = W_CLR;
            end
            W_CLR: begin
                fb_addr = wcnt;
                fb_clr  = 1'b1;
                if (wcnt == LAST) begin
                    fb_done  = 1'b1;
                    wr_clr   = 1'b1;
                    nx_state = IDLE;
                end else begin
                    // wcnt already holds the resume word when the read ends
                    nx_state = rd_pend ? R_REQ : W_SET;
                end
            end
            R_REQ: begin
                ext_rd   = 1'b1;
                ext_addr = {~frame, rd_v, rcnt};
                // A fresh blank edge restarts the fetch, discarding this ack
                if (ext_ack && !rd_edge) begin
                    r_ack = 1'b1;
                    if (rcnt == LAST)
                        nx_state = (wr_pend && dump_valid) ? W_SET : IDLE;
                end
            end
            default: nx_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line       <= 1'b0;
            have_lat   <= 1'b0;
            lat_frame  <= 1'b0;
            lat_v      <= '0;
            dump_valid <= 1'b0;
            dump_frame <= 1'b0;
            dump_v     <= '0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_v       <= '0;
            lhbl_l     <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            scr_we     <= 1'b0;
            fb_dout    <= '0;
            rd_addr    <= '0;
        end else begin
            lhbl_l <= lhbl;
            scr_we <= 1'b0;
            if (hs_ok) begin
                line                 <= ~line;
                {dump_frame, dump_v} <= {lat_frame, lat_v};
                {lat_frame, lat_v}   <= {frame, ln_v};
                have_lat             <= 1'b1;
                dump_valid           <= have_lat;
                wr_pend              <= 1'b1;
            end else if (wr_clr) begin
                wr_pend <= 1'b0;
            end
            if (state == W_CLR)
                wcnt <= (wcnt == LAST) ? '0 : wcnt + ONE;
            if (rd_edge) begin
                rd_pend <= 1'b1;
                rd_v    <= vrender;
                rcnt    <= '0;
            end else if (r_ack) begin
                scr_we  <= 1'b1;
                fb_dout <= ext_dout;
                rd_addr <= rcnt;
                if (rcnt == LAST) begin
                    rcnt    <= '0;
                    rd_pend <= 1'b0;
                end else begin
                    rcnt <= rcnt + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_lfbuf_sdctrl.sv
module tb_jtframe_lfbuf_sdctrl;
    localparam int VW = 8, HW = 9, HWORDS = 128, AW = VW + HW;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } tx_t;
    typedef struct packed {
        logic [HW-2:0] a;
        logic [31:0]   d;
    } scr_t;

    logic clk = 0, rst = 1, ln_hs = 0, frame = 0, lvbl = 1, lhbl = 1, ext_ack = 0;
    logic [VW-1:0] ln_v = '0, vrender = '0;
    logic [31:0] fb_din = '0, ext_dout = '0;
    logic line, fb_clr, fb_done, scr_we, ext_wr, ext_rd;
    logic [HW-2:0] fb_addr, rd_addr;
    logic [31:0] fb_dout, ext_din;
    logic [AW-1:0] ext_addr;

    int vectors = 0, miscompares = 0;
    int done_cnt = 0, ack_cnt = 0;
    logic [31:0] fbm[HWORDS];
    logic [31:0] exp_fb[HWORDS];
    tx_t  txq[$];
    logic [HW-2:0] clr_q[$];
    scr_t scr_q[$];

    jtframe_lfbuf_sdctrl #(.VW(VW), .HW(HW), .HWORDS(HWORDS)) dut (
        .clk(clk), .rst(rst), .ln_hs(ln_hs), .ln_v(ln_v), .frame(frame),
        .vrender(vrender), .lvbl(lvbl), .lhbl(lhbl), .line(line),
        .fb_addr(fb_addr), .fb_din(fb_din), .fb_clr(fb_clr), .fb_done(fb_done),
        .rd_addr(rd_addr), .fb_dout(fb_dout), .scr_we(scr_we),
        .ext_addr(ext_addr), .ext_wr(ext_wr), .ext_rd(ext_rd), .ext_din(ext_din),
        .ext_dout(ext_dout), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [AW-1:0] mk_addr(input logic f, input int v, input int w);
        logic [VW-1:0] vv;
        logic [HW-2:0] ww;
        vv = v[VW-1:0];
        ww = w[HW-2:0];
        return {f, vv, ww};
    endfunction

    // Input line-buffer model: 1-cycle read latency, clear on fb_clr
    always @(posedge clk) begin
        fb_din <= fbm[int'(fb_addr)];
        if (fb_clr) fbm[int'(fb_addr)] = '0;
    end

    // Event monitor and SDRAM responder (random latency, one outstanding)
    always @(negedge clk) begin
        if (fb_clr)  clr_q.push_back(fb_addr);
        if (fb_done) done_cnt++;
        if (scr_we)  scr_q.push_back(scr_t'{rd_addr, fb_dout});
        if (ext_wr || ext_rd) begin
            vectors++;
            if (ext_wr && ext_rd) begin
                miscompares++;
                $display("FAIL req_excl: ext_wr=%b ext_rd=%b, required not both", ext_wr, ext_rd);
            end
        end
        if (rst) begin
            ext_ack = 0;
            ack_cnt = 0;
        end else if (ext_ack) begin
            ext_ack = 0;
        end else if (ext_wr || ext_rd) begin
            if (ack_cnt == 0) ack_cnt = $urandom_range(1, 4);
            ack_cnt--;
            if (ack_cnt == 0) begin
                ext_ack = 1;
                if (ext_rd) ext_dout = rdata(ext_addr);
                txq.push_back(tx_t'{ext_rd, ext_addr, ext_rd ? rdata(ext_addr) : ext_din});
            end
        end
    end

    task automatic clear_log();
        txq.delete(); clr_q.delete(); scr_q.delete(); done_cnt = 0;
    endtask

    task automatic fill_line();
        for (int i = 0; i < HWORDS; i++) begin
            fbm[i] = $urandom;
            exp_fb[i] = fbm[i];
        end
    endtask

    task automatic pulse_hs(input int v);
        @(negedge clk);
        ln_v = v[VW-1:0];
        ln_hs = 1;
        @(negedge clk);
        ln_hs = 0;
    endtask

    task automatic wait_done(input int n, input int lim, output bit ok);
        int c = 0;
        while (done_cnt < n && c < lim) begin @(negedge clk); c++; end
        ok = (done_cnt >= n);
    endtask

    task automatic wait_wr_word(input int w, input int lim, output bit ok);
        int c = 0;
        ok = 0;
        while (!ok && c < lim) begin
            @(negedge clk); c++;
            if (ext_wr && int'(ext_addr[HW-2:0]) == w) ok = 1;
        end
    endtask

    task automatic check_writes(input string nm, input int v);
        vectors++;
        if (txq.size() !== HWORDS) begin
            miscompares++;
            $display("FAIL %s_count: got %0d transactions, required %0d", nm, txq.size(), HWORDS);
        end
        for (int i = 0; i < HWORDS && i < txq.size(); i++) begin
            vectors++;
            if (txq[i] !== tx_t'{1'b0, mk_addr(1'b0, v, i), exp_fb[i]}) begin
                miscompares++;
                $display("FAIL %s_tx[%0d]: got rd=%b addr=%h data=%h, required write addr=%h data=%h",
                         nm, i, txq[i].rd, txq[i].addr, txq[i].data, mk_addr(1'b0, v, i), exp_fb[i]);
            end
        end
    endtask

    task automatic check_clears(input string nm);
        int nz = 0;
        vectors++;
        if (clr_q.size() !== HWORDS) begin
            miscompares++;
            $display("FAIL %s_clr_count: got %0d, required %0d", nm, clr_q.size(), HWORDS);
        end
        for (int i = 0; i < HWORDS && i < clr_q.size(); i++) begin
            vectors++;
            if (int'(clr_q[i]) !== i) begin
                miscompares++;
                $display("FAIL %s_clr[%0d]: got fb_addr %0d, required %0d", nm, i, clr_q[i], i);
            end
        end
        for (int i = 0; i < HWORDS; i++) if (fbm[i] !== 32'd0) nz++;
        vectors++;
        if (nz !== 0) begin
            miscompares++;
            $display("FAIL %s_cleared: %0d words left non-zero, required 0", nm, nz);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        logic [127:0] o;
        o = {line, fb_addr, fb_clr, fb_done, rd_addr, fb_dout, scr_we, ext_addr, ext_wr, ext_rd};
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL %s: outputs %h, required all zero", nm, o);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 0;
    endtask

    task automatic test_invalid_dump(input string nm);
        frame = 0;
        clear_log();
        pulse_hs(5);
        repeat (2) @(negedge clk);
        vectors++;
        if (line !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_line: got %b, required 1", nm, line);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL %s_done: got %0d fb_done pulses, required 1", nm, done_cnt);
        end
        vectors++;
        if (txq.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_noaccess: got %0d SDRAM transactions, required 0", nm, txq.size());
        end
    endtask

    task automatic test_dump();
        bit ok;
        frame = 0;
        fill_line();
        clear_log();
        pulse_hs(6);
        vectors++;
        if (line !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_line: got %b, required 0", line);
        end
        wait_done(1, 4000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL dump_timeout: fb_done count %0d, required 1", done_cnt);
        end
        repeat (10) @(negedge clk);
        check_writes("dump", 5);
        check_clears("dump");
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL dump_done: got %0d fb_done pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_read();
        int c = 0;
        clear_log();
        @(negedge clk);
        frame = 1; vrender = 20; lhbl = 0;
        repeat (3) @(negedge clk);
        lhbl = 1;
        while (scr_q.size() < HWORDS && c < 4000) begin @(negedge clk); c++; end
        repeat (10) @(negedge clk);
        vectors++;
        if (txq.size() !== HWORDS || scr_q.size() !== HWORDS) begin
            miscompares++;
            $display("FAIL read_count: got %0d reads and %0d scr_we, required %0d each",
                     txq.size(), scr_q.size(), HWORDS);
        end
        for (int i = 0; i < HWORDS && i < txq.size() && i < scr_q.size(); i++) begin
            vectors++;
            if (txq[i].rd !== 1'b1 || txq[i].addr !== mk_addr(1'b0, 20, i) ||
                scr_q[i] !== scr_t'{i[HW-2:0], rdata(mk_addr(1'b0, 20, i))}) begin
                miscompares++;
                $display("FAIL read[%0d]: got rd=%b addr=%h rd_addr=%0d fb_dout=%h, required addr=%h rd_addr=%0d fb_dout=%h",
                         i, txq[i].rd, txq[i].addr, scr_q[i].a, scr_q[i].d,
                         mk_addr(1'b0, 20, i), i, rdata(mk_addr(1'b0, 20, i)));
            end
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL read_nodone: got %0d fb_done pulses, required 0", done_cnt);
        end
        frame = 0;
    endtask

    task automatic test_interleave();
        bit ok;
        int rv;
        tx_t expq[$];
        rv = $urandom_range(0, 255);
        fill_line();
        clear_log();
        pulse_hs(7);
        wait_wr_word(40, 2000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL interleave_reach40: word 40 never requested, required a write");
        end
        vrender = rv[VW-1:0];
        lhbl = 0;
        repeat (2) @(negedge clk);
        lhbl = 1;
        wait_done(1, 6000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL interleave_timeout: fb_done count %0d, required 1", done_cnt);
        end
        repeat (10) @(negedge clk);
        for (int w = 0; w <= 40; w++) expq.push_back(tx_t'{1'b0, mk_addr(1'b0, 6, w), exp_fb[w]});
        for (int r = 0; r < HWORDS; r++) expq.push_back(tx_t'{1'b1, mk_addr(1'b1, rv, r), rdata(mk_addr(1'b1, rv, r))});
        for (int w = 41; w < HWORDS; w++) expq.push_back(tx_t'{1'b0, mk_addr(1'b0, 6, w), exp_fb[w]});
        vectors++;
        if (txq.size() !== expq.size()) begin
            miscompares++;
            $display("FAIL interleave_count: got %0d transactions, required %0d", txq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
            vectors++;
            if (txq[i] !== expq[i]) begin
                miscompares++;
                $display("FAIL interleave_tx[%0d]: got rd=%b addr=%h data=%h, required rd=%b addr=%h data=%h",
                         i, txq[i].rd, txq[i].addr, txq[i].data, expq[i].rd, expq[i].addr, expq[i].data);
            end
        end
        vectors++;
        if (scr_q.size() !== HWORDS) begin
            miscompares++;
            $display("FAIL interleave_scr: got %0d scr_we pulses, required %0d", scr_q.size(), HWORDS);
        end
        check_clears("interleave");
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL interleave_done: got %0d fb_done pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_hs_drop();
        bit ok;
        fill_line();
        clear_log();
        pulse_hs(8);
        wait_wr_word(20, 2000, ok);
        pulse_hs(9);
        vectors++;
        if (line !== 1'b0) begin
            miscompares++;
            $display("FAIL hsdrop_line: got %b, required 0", line);
        end
        wait_done(1, 4000, ok);
        repeat (40) @(negedge clk);
        check_writes("hsdrop", 7);
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL hsdrop_done: got %0d fb_done pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        fill_line();
        clear_log();
        pulse_hs(10);
        wait_wr_word(10, 2000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rstmid_reach10: word 10 never requested, required a write");
        end
        rst = 1;
        @(posedge clk);
        #1;
        check_outputs_zero("rstmid_outputs");
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        test_invalid_dump("rstmid_after");
    endtask

    initial begin
        for (int i = 0; i < HWORDS; i++) fbm[i] = '0;
        test_reset();
        test_invalid_dump("first_hs");
        test_dump();
        test_read();
        test_interleave();
        test_hs_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtframe_lfbuf_sdctrl.md
Name: jtframe_lfbuf_sdctrl

Overview:
- SDRAM-side controller for the line-based frame buffer, the memory end of the line-buffer interface.
- Dumps each completed object line from the input line buffer to SDRAM, clearing it behind itself, then pulses fb_done.
- During every horizontal blank, fetches the next displayed line from the opposite frame into the output line buffer.
- Sits between the line-buffer block and a 32-bit single-outstanding SDRAM port.

Parameters:
- VW, 8, vertical line-number width.
- HW, 9, horizontal pixel-address width; each 32-bit word carries 2 pixels.
- HWORDS, 128, 32-bit words per line (must be ≤ 2^(HW-1)).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ln_hs  in  1  one-cycle pulse: drawing of line ln_v begins in buffer half ~line.
- ln_v  in  VW  line now being drawn.
- frame  in  1  frame currently written; the displayed frame is ~frame.
- vrender  in  VW  line to fetch for display.
- lvbl  in  1  vertical blank, active low.
- lhbl  in  1  horizontal blank, active low.
- line  out  1  input line-buffer half being dumped.
- fb_addr  out  HW-1  word address into the dump half.
- fb_din  in  32  dump-half data; 1-cycle read latency.
- fb_clr  out  1  clear strobe for word fb_addr.
- fb_done  out  1  one-cycle pulse: dump finished.
- rd_addr  out  HW-1  output line-buffer write address.
- fb_dout  out  32  output line-buffer write data.
- scr_we  out  1  output line-buffer write strobe.
- ext_addr  out  VW+HW  SDRAM word address {frame bit, line, word}.
- ext_wr  out  1  write request, held until ext_ack.
- ext_rd  out  1  read request, held until ext_ack.
- ext_din  out  32  write data; equals fb_din.
- ext_dout  in  32  read data, valid on the ext_ack cycle of a read.
- ext_ack  in  1  transaction complete; only one request is outstanding at a time.

Behaviour:
- Reset: all outputs 0.
  - Internal: dump_valid=0, wr_pend=0, rd_pend=0, state=IDLE.
- ln_hs handling:
  - line toggles.
  - {dump_frame, dump_v} ← previous latched {frame, ln_v}; this pair is captured on every ln_hs.
  - wr_pend ← 1.
  - dump_valid ← 1 after the first ln_hs following reset.
- A second ln_hs while wr_pend or WRITE is active is dropped.
- lhbl falling edge with lvbl=1 sets rd_pend and latches rd_v=vrender.
  - A new edge during READ aborts that read and restarts at word 0 with the new rd_v.
- State IDLE:
  - rd_pend has priority → READ; otherwise wr_pend → WRITE.
  - If wr_pend is set and dump_valid=0: pulse fb_done one cycle, clear wr_pend, no SDRAM access.
- State WRITE, per word w (0..HWORDS-1):
  - Cycle 0: fb_addr=w (BRAM settle).
  - Cycle 1: assert ext_wr with ext_addr={dump_frame,dump_v,w}.
  - On ext_ack: drop ext_wr and pulse fb_clr for one cycle with fb_addr=w.
  - Next word: w+1.
  - After word HWORDS-1: fb_done pulse one cycle, wr_pend←0 → IDLE.
  - If rd_pend is set at a word boundary (after the ack/clr): save w+1 → READ.
  - After READ ends, resume WRITE at the saved word; the clear already done is not repeated.
- State READ, per word r:
  - Assert ext_rd with ext_addr={~frame,rd_v,r}.
  - On ext_ack: fb_dout←ext_dout, rd_addr←r, scr_we=1 for exactly one cycle.
  - After word HWORDS-1: rd_pend←0 → WRITE if a write is suspended or wr_pend, else IDLE.
- ext_wr/ext_rd are never both high; the request level is held stable until ext_ack.
- ext_ack while no request is asserted is ignored.
- Address arithmetic: word counters wrap at HWORDS, never at 2^(HW-1); line numbers are not incremented.
- Reset mid-transfer returns to IDLE immediately.
  - Requests drop on the same edge.
  - The partially dumped line is lost (not cleared).

Test Plan:
- Reset, then ln_hs with ln_v=5, frame=0 → line=1, fb_done pulses within 2 cycles, no ext_wr.
- Second ln_hs with ln_v=6, SDRAM acking after 3 cycles → 128 ext_wr at addresses {0,5,0..127}, each followed by a one-cycle fb_clr at the same fb_addr; exactly one fb_done after the last ack.
- During idle, lhbl falls with vrender=20, frame=1 → 128 ext_rd at {0,20,r}; scr_we pulses 128 times with rd_addr 0..127 and fb_dout equal to the returned data.
- Start a dump and let lhbl fall at word 40 → word 40 completes, reads run all 128 words, then writes resume at word 41; total fb_clr count is 128 and total fb_done count is 1.
- ln_hs during an active dump → ignored; exactly one fb_done follows.
- Assert rst while ext_wr is high at word 10 → all outputs 0 on the next edge; a subsequent ln_hs behaves as in the first scenario.
